dmem_arbiter: RTL
=================

# dmem_arbiter

Shares the single data-memory port between the single-cycle core's load/store path and an external loader/debug master. A round-robin arbiter with an external lock and a bounded lock counter sequences every access through a three-state FSM and stalls the core, via `cpu_stall`, while its access is pending. It sits between the core's ALU-address/rs2-data path and the DMEM instance.

## Interface
- `ADDR_W`, default 32: address width on all ports.
- `DATA_W`, default 32: data width on all ports.
- `LOCK_MAX`, default 4: maximum consecutive locked ext grants while `cpu_req` is pending.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  core load/store request; held with fields stable until `cpu_ack`.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_addr`  in  ADDR_W  byte address.
- `cpu_wdata`  in  DATA_W  store data.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  DATA_W  load data.
- `cpu_stall`  out  1  `cpu_req & ~cpu_ack`; freezes the core PC and register write.
- `ext_req`, `ext_we`, `ext_addr`, `ext_wdata`  in  same widths and rules as the cpu fields.
- `ext_lock`  in  1  request to keep ownership across consecutive ext accesses.
- `ext_ack`  out  1  one-cycle completion pulse.
- `ext_rdata`  out  DATA_W  load data.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid the cycle after `mem_en`.
- `busy`  out  1  FSM not in IDLE.
- `owner`  out  1  0 = cpu, 1 = ext; the current or last grant.

## Operation
- FSM states are IDLE, ISSUE and RESP. Every access passes IDLE → ISSUE → RESP → IDLE; there is no bypass.
- **IDLE.** If `cpu_req` or `ext_req` is high, select a winner, latch its `we`/`addr`/`wdata` into internal registers, set `owner`, and go to ISSUE. Otherwise stay in IDLE.
- **Winner selection,** in priority order:
  - Only one request high: that requester wins.
  - Both high, `ext_lock=1`, `owner=1` and `lock_cnt<LOCK_MAX`: ext wins and `lock_cnt` increments.
  - Both high otherwise: the requester not equal to `owner` wins (round-robin).
- **`lock_cnt` updates:**
  - Clears whenever cpu wins.
  - Clears whenever ext wins with `cpu_req=0`.
  - Saturates at `LOCK_MAX`.
  - Once saturated with `cpu_req` high, the next arbitration goes to cpu by round-robin.
- **ISSUE.** `mem_en=1`; `mem_we`/`mem_addr`/`mem_wdata` come from the latched registers. Go to RESP.
- **RESP.**
  - The owner's ack is 1.
  - The owner's rdata equals `mem_rdata` combinationally, and the same value loads into that port's rdata hold register.
  - For a store, rdata carries don't-care memory output; the hold register still updates.
  - Go to IDLE.
- Outside RESP, each rdata output presents its hold register. The non-owner's rdata never changes.
- `mem_en=0` and `mem_we=0` in IDLE and RESP. `mem_addr`/`mem_wdata` hold their latched values.
- A requester must deassert req, or present a new request, in the cycle after its ack. A req still high in IDLE is treated as a new access.
- A request dropped before ack is a protocol violation. The arbiter still completes the latched access.

## Timing
- Reset (`rst` high at an edge) sets: state=IDLE, `owner=1` (so cpu wins the first contested grant), `lock_cnt=0`, both rdata hold registers 0, all latched fields 0.
- Outputs after reset: `cpu_ack=0`, `ext_ack=0`, `mem_en=0`, `mem_we=0`, `busy=0`, `mem_addr=0`, `mem_wdata=0`.
- Reset mid-access aborts it: no ack is issued and any ISSUE write is dropped if `rst` is sampled at that edge.
- Latency: req sampled high at edge E0 in IDLE gives ISSUE in cycle E0–E1 and ack in cycle E1–E2. An isolated access therefore takes 3 cycles including the IDLE sample.
- Throughput: one access per 3 cycles. Contested requesters alternate at 3-cycle granularity.
- `cpu_stall` is combinational and is high from the first cycle `cpu_req` is high through the cycle before `cpu_ack`. It is low in the ack cycle.
- A simultaneous first request from both ports after reset is granted to cpu.

## Test plan
- Single cpu load: preload mem[0x40]=0xDEADBEEF; `cpu_req=1`, `we=0`, `addr=0x40` → `mem_en` high exactly one cycle; `cpu_ack` in 3rd cycle with `cpu_rdata=0xDEADBEEF`; `cpu_stall` high 2 cycles.
- Store then load, ext: ext writes 0x12345678 to 0x80, then reads 0x80 → `mem_we=1` only in the write's ISSUE cycle; read returns 0x12345678; `cpu_rdata` unchanged (0).
- Contention from reset: both req high continuously → grant order cpu, ext, cpu, ext; acks every 3 cycles alternating.
- Lock bound, `LOCK_MAX=4`: ext wins first, `ext_lock=1`, `cpu_req` held high → exactly 4 consecutive locked ext grants after the first, then a cpu grant; `cpu_stall` drops at that ack.
- Reset mid-access: assert `rst` during ISSUE of a cpu store to 0x10 → no `cpu_ack`; FSM IDLE; `busy=0`; `owner=1`; mem[0x10] unchanged.
- Lock without contention: `ext_lock=1`, `cpu_req=0`, 10 ext accesses → all granted; `lock_cnt` stays 0; a later `cpu_req` is granted at the next IDLE.

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Round-robin/lockable arbiter sharing one data-memory port between
//            the core load/store path and an external loader/debug master.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    // core load/store port
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    // external master port
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    input  logic              ext_lock,
    output logic              ext_ack,
    output logic [DATA_W-1:0] ext_rdata,
    // memory port
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    // status
    output logic              busy,
    output logic              owner
);

    localparam int c_CNT_W = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_LOCK_MAX = c_CNT_W'(LOCK_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_owner;
    logic [c_CNT_W-1:0]  r_lock_cnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_cpu_rdata;
    logic [DATA_W-1:0]   r_ext_rdata;

    logic                w_any_req;
    logic                w_both;
    logic                w_lock_win;
    logic                w_pick_ext;
    logic                w_grant;
    logic                w_resp;

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
    assign w_any_req  = cpu_req | ext_req;
    assign w_both     = cpu_req & ext_req;
    assign w_lock_win = w_both & ext_lock & r_owner & (r_lock_cnt < c_LOCK_MAX);
    // Contested without a valid lock: the side that did not own last wins.
    assign w_pick_ext = (ext_req & ~cpu_req)
                      | w_lock_win
                      | (w_both & ~w_lock_win & ~r_owner);
    assign w_grant    = (r_state == S_IDLE) & w_any_req;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_any_req) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_owner     <= 1'b1;
            r_lock_cnt  <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_ext_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_grant) begin
                r_owner <= w_pick_ext;
                r_we    <= w_pick_ext ? ext_we    : cpu_we;
                r_addr  <= w_pick_ext ? ext_addr  : cpu_addr;
                r_wdata <= w_pick_ext ? ext_wdata : cpu_wdata;

                if (w_lock_win) begin
                    if (r_lock_cnt != c_LOCK_MAX) begin
                        r_lock_cnt <= r_lock_cnt + 1'b1;
                    end
                end else if (!w_pick_ext || !cpu_req) begin
                    r_lock_cnt <= '0;
                end
            end

            // Stores also refresh the hold register with whatever memory returns.
            if (r_state == S_RESP) begin
                if (r_owner) begin
                    r_ext_rdata <= mem_rdata;
                end else begin
                    r_cpu_rdata <= mem_rdata;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Reset in the same cycle suppresses strobes so an aborted access has no effect.
    assign w_resp    = (r_state == S_RESP) & ~rst;

    assign cpu_ack   = w_resp & ~r_owner;
    assign ext_ack   = w_resp &  r_owner;
    assign cpu_rdata = cpu_ack ? mem_rdata : r_cpu_rdata;
    assign ext_rdata = ext_ack ? mem_rdata : r_ext_rdata;
    assign cpu_stall = cpu_req & ~cpu_ack;

    assign mem_en    = (r_state == S_ISSUE) & ~rst;
    assign mem_we    = mem_en & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign busy      = (r_state != S_IDLE);
    assign owner     = r_owner;

endmodule
`default_nettype wire
